// File: rtl/fp_pkg.sv
// Shared binary32 constants, round-mode encodings and the multiplier FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SIG_W  = 24;   // mantissa plus hidden bit
  localparam int PROD_W = 48;   // full 24x24 significand product

  // Exponent arithmetic is 10-bit signed so underflow and overflow stay visible.
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MAX  = 10'sd255;

  localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;

  localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // toward zero
  localparam logic [1:0] RM_RUP = 2'b10;  // toward +inf
  localparam logic [1:0] RM_RDN = 2'b11;  // toward -inf

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MUL,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Classifies one binary32 operand and produces its 24-bit significand with hidden bit.
// Latency: combinational.
// Backpressure: none, pure function of x.
// Ports: x (operand in); sign, exp_v (unbiased-free 10-bit signed exponent), man (significand),
//        is_zero / is_inf / is_nan (class flags; a normal or normalised subnormal sets none).
// FP_MUL_DENORM_EN: subnormals are normalised (leading one moved to bit 23, exponent lowered);
//        without it they are reported as zero.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       x,
  output logic              sign,
  output logic signed [9:0] exp_v,
  output logic [SIG_W-1:0]  man,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;

  assign e = x[30:23];
  assign f = x[22:0];

`ifdef FP_MUL_DENORM_EN
  logic [4:0] lead;
  logic [4:0] lz_sh;
`endif

  always_comb begin
    sign    = x[31];
    is_nan  = (e == INF_EXP) && (f != '0);
    is_inf  = (e == INF_EXP) && (f == '0);
    is_zero = 1'b0;
    exp_v   = {2'b00, e};
    man     = {1'b1, f};
`ifdef FP_MUL_DENORM_EN
    lead  = 5'd0;
    lz_sh = 5'd0;
`endif
    if (e == '0) begin
`ifdef FP_MUL_DENORM_EN
      if (f == '0) begin
        is_zero = 1'b1;
      end else begin
        // Subnormal is 0.f x 2^(1-bias): shift the leading one up to the hidden
        // position and charge the shift against the exponent.
        for (int i = 0; i < MAN_W; i++) begin
          if (f[i]) lead = 5'(i);
        end
        lz_sh = 5'd23 - lead;
        man   = {1'b0, f} << lz_sh;
        exp_v = 10'sd1 - $signed({5'd0, lz_sh});
      end
`else
      is_zero = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier producing an unrounded result plus guard/round/sticky.
// Latency: 26 cycles from acceptance for finite operands, 2 cycles for special operands.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, rst (async active-high); in_valid/in_ready, op_a, op_b, round_mode_in (request);
//        out_valid/out_ready, out_data, out_guard/out_round/out_sticky, round_mode_out, out_invalid.
// FP_MUL_DENORM_EN: enables subnormal inputs and gradual-underflow results; otherwise flush to zero.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int D_Len = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_Len-1:0] op_a,
  input  logic [D_Len-1:0] op_b,
  input  logic [1:0]       round_mode_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_Len-1:0] out_data,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic [1:0]       round_mode_out,
  output logic             out_invalid
);

  state_t state_q, state_d;

  logic [D_Len-1:0]  a_q, b_q, res_q;
  logic [1:0]        rm_q;
  logic [4:0]        cnt_q;
  logic [PROD_W-1:0] prod_q;
  logic [SIG_W-1:0]  mcand_q;
  logic              sign_q, spc_phase_q;
  logic signed [9:0] exp_q;
  logic              g_q, r_q, s_q, inv_q;

  logic              ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
  logic signed [9:0] ua_exp, ub_exp;
  logic [SIG_W-1:0]  ua_man, ub_man;

  fp_unpack u_unpack_a (.x(a_q), .sign(ua_sign), .exp_v(ua_exp), .man(ua_man),
                        .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan));
  fp_unpack u_unpack_b (.x(b_q), .sign(ub_sign), .exp_v(ub_exp), .man(ub_man),
                        .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan));

  logic        res_sign, spc_any, spc_inv;
  logic [31:0] spc_res;

  always_comb begin
    res_sign = ua_sign ^ ub_sign;
    spc_inv  = ua_nan | ub_nan | (ua_inf & ub_zero) | (ua_zero & ub_inf);
    spc_any  = spc_inv | ua_inf | ub_inf | ua_zero | ub_zero;
    if (spc_inv)              spc_res = QNAN;
    else if (ua_inf | ub_inf) spc_res = {res_sign, INF_EXP, {MAN_W{1'b0}}};
    else                      spc_res = {res_sign, 31'd0};
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the whole product/multiplier register right by one.
  logic [SIG_W:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[PROD_W-1:SIG_W]} + {1'b0, (prod_q[0] ? mcand_q : {SIG_W{1'b0}})};

  // Normalisation of the finished product (leading one at bit 47 or 46).
  logic signed [9:0] exp_n;
  logic [MAN_W-1:0]  m_n;
  logic              g_n, r_n, s_n;
  logic [31:0]       norm_res;
  logic              norm_g, norm_r, norm_s;
`ifdef FP_MUL_DENORM_EN
  logic [9:0]  dn_sh;
  logic [25:0] dn_ext, dn_tmp, dn_lost;
`endif

  always_comb begin
    norm_g = 1'b0;
    norm_r = 1'b0;
    norm_s = 1'b0;
`ifdef FP_MUL_DENORM_EN
    dn_sh   = '0;
    dn_ext  = '0;
    dn_tmp  = '0;
    dn_lost = '0;
`endif
    if (prod_q[47]) begin
      exp_n = exp_q + 10'sd1;
      m_n   = prod_q[46:24];
      g_n   = prod_q[23];
      r_n   = prod_q[22];
      s_n   = |prod_q[21:0];
    end else begin
      exp_n = exp_q;
      m_n   = prod_q[45:23];
      g_n   = prod_q[22];
      r_n   = prod_q[21];
      s_n   = |prod_q[20:0];
    end
    norm_res = {sign_q, exp_n[7:0], m_n};
    norm_g   = g_n;
    norm_r   = r_n;
    norm_s   = s_n;
    if (exp_n >= EXP_MAX) begin
      norm_res = {sign_q, INF_EXP, {MAN_W{1'b0}}};
      norm_g   = 1'b0;
      norm_r   = 1'b0;
      norm_s   = 1'b0;
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
      norm_g   = 1'b0;
      norm_r   = 1'b0;
      norm_s   = 1'b0;
`ifdef FP_MUL_DENORM_EN
      dn_sh = 10'sd1 - exp_n;
      if (dn_sh > 10'd25) begin
        norm_s = 1'b1;
      end else begin
        // Shift by dn_sh-1 keeps the last shifted-out bit at dn_tmp[0]; it and
        // everything below it fold into sticky.
        dn_ext   = {1'b1, m_n, g_n, r_n};
        dn_tmp   = dn_ext >> (dn_sh[4:0] - 5'd1);
        dn_lost  = dn_ext & ~({26{1'b1}} << (dn_sh[4:0] - 5'd1));
        norm_res = {sign_q, 8'h00, dn_tmp[25:3]};
        norm_g   = dn_tmp[2];
        norm_r   = dn_tmp[1];
        norm_s   = s_n | dn_tmp[0] | (|dn_lost);
      end
`endif
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state and handshake outputs. Specials spend a second UNPACK cycle
  // so the result register is loaded before DONE presents it.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = UNPACK;
      end
      UNPACK: begin
        if (!spc_any)         state_d = MUL;
        else if (spc_phase_q) state_d = DONE;
      end
      MUL:  if (cnt_q == 5'(SIG_W - 1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      spc_phase_q <= 1'b0;
      res_q       <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q  <= op_a;
            b_q  <= op_b;
            rm_q <= round_mode_in;
          end
          spc_phase_q <= 1'b0;
        end
        UNPACK: begin
          sign_q  <= res_sign;
          exp_q   <= ua_exp + ub_exp - EXP_BIAS;
          prod_q  <= {{SIG_W{1'b0}}, ub_man};
          mcand_q <= ua_man;
          cnt_q   <= '0;
          if (spc_any) begin
            spc_phase_q <= 1'b1;
            res_q       <= spc_res;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            inv_q       <= spc_inv;
          end
        end
        MUL: begin
          prod_q <= {mul_sum, prod_q[SIG_W-1:1]};
          cnt_q  <= cnt_q + 5'd1;
        end
        NORM: begin
          res_q <= norm_res;
          g_q   <= norm_g;
          r_q   <= norm_r;
          s_q   <= norm_s;
          inv_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_data       = res_q;
  assign out_guard      = g_q;
  assign out_round      = r_q;
  assign out_sticky     = s_q;
  assign round_mode_out = rm_q;
  assign out_invalid    = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b, out_data;
  logic [1:0]  round_mode_in, round_mode_out;
  logic        out_guard, out_round, out_sticky, out_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_seq #(.D_Len(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .round_mode_in(round_mode_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .round_mode_out(round_mode_out), .out_invalid(out_invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one operand pair, then waits (bounded) for out_valid. lat is the
  // number of rising edges after the accepting edge; 60 means it never came.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    op_a = a; op_b = b; round_mode_in = rm; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 00000000", out_data); end
    n_checks++; if ({out_guard, out_round, out_sticky} !== 3'b000) begin n_fail++; $display("FAIL rst_grs: got %b want 000", {out_guard, out_round, out_sticky}); end
    n_checks++; if (round_mode_out !== 2'b00) begin n_fail++; $display("FAIL rst_rm_out: got %b want 00", round_mode_out); end
    n_checks++; if (out_invalid !== 1'b0) begin n_fail++; $display("FAIL rst_invalid: got %b want 0", out_invalid); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_mul_basic();
    int lat;
    // 3.0 * 2.0 = 6.0, exact.
    run_op(32'h40400000, 32'h40000000, 2'b01, lat);
    n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL mul_latency: got %0d want 26", lat); end
    n_checks++; if (out_data !== 32'h40C00000) begin n_fail++; $display("FAIL mul_data: got %h want 40C00000", out_data); end
    n_checks++; if ({out_guard, out_round, out_sticky} !== 3'b000) begin n_fail++; $display("FAIL mul_grs: got %b want 000", {out_guard, out_round, out_sticky}); end
    n_checks++; if (out_invalid !== 1'b0) begin n_fail++; $display("FAIL mul_invalid: got %b want 0", out_invalid); end
    n_checks++; if (round_mode_out !== 2'b01) begin n_fail++; $display("FAIL mul_rm_out: got %b want 01", round_mode_out); end
    take_result();
  endtask

  task automatic test_sticky();
    int lat;
    // (1+2^-23)^2 = 1 + 2^-22 + 2^-46: only sticky catches the 2^-46 term.
    run_op(32'h3F800001, 32'h3F800001, 2'b10, lat);
    n_checks++; if (out_data !== 32'h3F800002) begin n_fail++; $display("FAIL sticky_data: got %h want 3F800002", out_data); end
    n_checks++; if ({out_guard, out_round, out_sticky} !== 3'b001) begin n_fail++; $display("FAIL sticky_grs: got %b want 001", {out_guard, out_round, out_sticky}); end
    n_checks++; if (round_mode_out !== 2'b10) begin n_fail++; $display("FAIL sticky_rm_out: got %b want 10", round_mode_out); end
    take_result();
  endtask

  task automatic test_specials();
    int lat;
    run_op(32'h7F800000, 32'h00000000, 2'b00, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL inf0_latency: got %0d want 2", lat); end
    n_checks++; if (out_data !== 32'h7FC00000) begin n_fail++; $display("FAIL inf0_data: got %h want 7FC00000", out_data); end
    n_checks++; if (out_invalid !== 1'b1) begin n_fail++; $display("FAIL inf0_invalid: got %b want 1", out_invalid); end
    take_result();

    run_op(32'h7F000000, 32'h40000000, 2'b00, lat);
    n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL ovf_latency: got %0d want 26", lat); end
    n_checks++; if (out_data !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_data: got %h want 7F800000", out_data); end
    n_checks++; if ({out_guard, out_round, out_sticky, out_invalid} !== 4'b0000) begin n_fail++; $display("FAIL ovf_grs_inv: got %b want 0000", {out_guard, out_round, out_sticky, out_invalid}); end
    take_result();

    run_op(32'h7FC12345, 32'h3F800000, 2'b00, lat);
    n_checks++; if ({out_data, out_invalid} !== {32'h7FC00000, 1'b1}) begin n_fail++; $display("FAIL nan_data_inv: got %h/%b want 7FC00000/1", out_data, out_invalid); end
    take_result();

    run_op(32'hFF800000, 32'h40000000, 2'b00, lat);
    n_checks++; if ({out_data, out_invalid} !== {32'hFF800000, 1'b0}) begin n_fail++; $display("FAIL ninf_data_inv: got %h/%b want FF800000/0", out_data, out_invalid); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ninf_latency: got %0d want 2", lat); end
    take_result();

    run_op(32'h80000000, 32'h40000000, 2'b00, lat);
    n_checks++; if ({out_data, out_invalid} !== {32'h80000000, 1'b0}) begin n_fail++; $display("FAIL nzero_data_inv: got %h/%b want 80000000/0", out_data, out_invalid); end
    take_result();
  endtask

  task automatic test_denorm();
    int lat;
    logic [31:0] want_a, want_b;
    int          want_lat_b;
    logic        want_s_c;
`ifdef FP_MUL_DENORM_EN
    want_a = 32'h00400000; want_b = 32'h00800000; want_lat_b = 26; want_s_c = 1'b1;
`else
    want_a = 32'h00000000; want_b = 32'h00000000; want_lat_b = 2;  want_s_c = 1'b0;
`endif
    // 2^-126 * 0.5 underflows to the largest-power subnormal.
    run_op(32'h00800000, 32'h3F000000, 2'b00, lat);
    n_checks++; if (out_data !== want_a) begin n_fail++; $display("FAIL uflow_data: got %h want %h", out_data, want_a); end
    n_checks++; if ({out_guard, out_round, out_sticky} !== 3'b000) begin n_fail++; $display("FAIL uflow_grs: got %b want 000", {out_guard, out_round, out_sticky}); end
    take_result();
    // Subnormal input 2^-127 times 2.0.
    run_op(32'h00400000, 32'h40000000, 2'b00, lat);
    n_checks++; if (out_data !== want_b) begin n_fail++; $display("FAIL subin_data: got %h want %h", out_data, want_b); end
    n_checks++; if (lat !== want_lat_b) begin n_fail++; $display("FAIL subin_latency: got %0d want %0d", lat, want_lat_b); end
    take_result();
    // 2^-126 * 2^-126: shift far beyond the field gives signed zero.
    run_op(32'h00800000, 32'h80800000, 2'b00, lat);
    n_checks++; if (out_data !== 32'h80000000) begin n_fail++; $display("FAIL deep_data: got %h want 80000000", out_data); end
    n_checks++; if (out_sticky !== want_s_c) begin n_fail++; $display("FAIL deep_sticky: got %b want %b", out_sticky, want_s_c); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h40400000, 32'h40000000, 2'b10, lat);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake: cycle %0d got v/r %b%b want 10", i, out_valid, in_ready); end
      n_checks++; if ({out_data, round_mode_out} !== {32'h40C00000, 2'b10}) begin n_fail++; $display("FAIL bp_hold: cycle %0d got %h/%b want 40C00000/10", i, out_data, round_mode_out); end
      @(negedge clk);
    end
    take_result();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v/r %b%b want 01", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses;
    @(negedge clk);
    op_a = 32'h40400000; op_b = 32'h40000000; round_mode_in = 2'b11; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (round_mode_out !== 2'b11) begin n_fail++; $display("FAIL mid_rm_latched: got %b want 11", round_mode_out); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_checks++; if ({out_data, out_guard, out_round, out_sticky, round_mode_out, out_invalid} !== 38'h0) begin n_fail++; $display("FAIL mid_outputs: got %h/%b%b%b/%b/%b want all zero", out_data, out_guard, out_round, out_sticky, round_mode_out, out_invalid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d valid cycles want 0", pulses); end
    run_op(32'h3FC00000, 32'h3FC00000, 2'b00, lat);
    n_checks++; if (out_data !== 32'h40100000) begin n_fail++; $display("FAIL post_rst_data: got %h want 40100000", out_data); end
    n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL post_rst_latency: got %0d want 26", lat); end
    take_result();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; round_mode_in = 2'b00;
    #1;
    test_reset();
    test_mul_basic();
    test_sticky();
    test_specials();
    test_denorm();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
